// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle core sequencer: states, trap causes,
// access sizes and the reset NOP.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [3:0] CAUSE_FETCH_TMO = 4'd1;
    localparam logic [3:0] CAUSE_LD_MISAL  = 4'd4;
    localparam logic [3:0] CAUSE_LD_TMO    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL  = 4'd6;
    localparam logic [3:0] CAUSE_ST_TMO    = 4'd7;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Size code 3 is undefined and is treated as never trapping.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_irq_prio.sv
// Masked interrupt priority encoder: lowest enabled index wins.
module core_irq_prio #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               valid,
    output logic [3:0]         idx
);

    logic [NUM_IRQ-1:0] pend;
    assign pend = irq & irq_mask;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/core_mc.sv
// Multi-cycle core sequencer: PC, instruction register, fetch/data handshakes,
// interrupts and traps. Define CORE_MC_BUS_TIMEOUT_EN to add bus wait timeouts.
module core_mc
    import core_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RST_PC_ADDRESS = 32'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR    = 32'h100,
    parameter int              NUM_IRQ        = 8,
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               i_req,
    output logic [XLEN-1:0]    i_addr,
    input  logic               i_ready,
    input  logic [31:0]        i_rdata,
    output logic [31:0]        instr,
    output logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    ex_pc_next,
    input  logic               ex_rd_wen,
    input  logic               ex_is_load,
    input  logic               ex_is_store,
    input  logic [XLEN-1:0]    ex_addr,
    input  logic [XLEN-1:0]    ex_wdata,
    input  logic [1:0]         ex_size,
    output logic               d_req,
    output logic               d_we,
    output logic [XLEN-1:0]    d_addr,
    output logic [XLEN-1:0]    d_wdata,
    output logic [1:0]         d_size,
    input  logic               d_ready,
    input  logic [XLEN-1:0]    d_rdata,
    output logic [XLEN-1:0]    load_data,
    output logic               rf_we,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               trap,
    output logic [4:0]         trap_cause,
    output logic [XLEN-1:0]    epc
);

    state_t     state;
    logic       irq_vld;
    logic [3:0] irq_idx;
    logic       mem_op;
    logic       misal;

    core_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_irq_prio (
        .irq      (irq),
        .irq_mask (irq_mask),
        .valid    (irq_vld),
        .idx      (irq_idx)
    );

    assign i_addr = pc;
    assign mem_op = ex_is_load | ex_is_store;
    assign misal  = mem_op & misaligned(ex_addr[1:0], ex_size);

`ifdef CORE_MC_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Hit on the last allowed wait cycle; a ready in that cycle still wins.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if ((i_req & ~i_ready) | (d_req & ~d_ready))
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RST_PC_ADDRESS;
            instr      <= NOP;
            i_req      <= 1'b0;
            d_req      <= 1'b0;
            d_we       <= 1'b0;
            d_addr     <= '0;
            d_wdata    <= '0;
            d_size     <= '0;
            load_data  <= '0;
            rf_we      <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= '0;
            epc        <= '0;
        end else begin
            rf_we <= 1'b0;
            trap  <= 1'b0;
            case (state)
                ST_FETCH: begin
                    // First cycle out of reset raises the request; later
                    // entries into FETCH arrive with i_req already set.
                    if (!i_req) begin
                        i_req <= 1'b1;
                    end else if (i_ready) begin
                        instr <= i_rdata;
                        i_req <= 1'b0;
                        state <= ST_EXEC;
                    end
`ifdef CORE_MC_BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        i_req      <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= {1'b0, CAUSE_FETCH_TMO};
                        epc        <= pc;
                        state      <= ST_TRAP;
                    end
`endif
                end
                ST_EXEC: begin
                    if (misal) begin
                        trap       <= 1'b1;
                        trap_cause <= {1'b0, ex_is_store ? CAUSE_ST_MISAL : CAUSE_LD_MISAL};
                        epc        <= pc;
                        state      <= ST_TRAP;
                    end else if (mem_op) begin
                        d_req   <= 1'b1;
                        d_we    <= ex_is_store;
                        d_addr  <= ex_addr;
                        d_wdata <= ex_wdata;
                        d_size  <= ex_size;
                        state   <= ST_MEM;
                    end else begin
                        rf_we <= ex_rd_wen & ~ex_is_store;
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (d_ready) begin
                        if (!d_we)
                            load_data <= d_rdata;
                        d_req <= 1'b0;
                        d_we  <= 1'b0;
                        rf_we <= ex_rd_wen & ~ex_is_store;
                        state <= ST_WB;
                    end
`ifdef CORE_MC_BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        d_req      <= 1'b0;
                        d_we       <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= {1'b0, d_we ? CAUSE_ST_TMO : CAUSE_LD_TMO};
                        epc        <= pc;
                        state      <= ST_TRAP;
                    end
`endif
                end
                ST_WB: begin
                    pc <= ex_pc_next;
                    if (irq_vld) begin
                        trap       <= 1'b1;
                        trap_cause <= {1'b1, irq_idx};
                        epc        <= ex_pc_next;
                        state      <= ST_TRAP;
                    end else begin
                        i_req <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_TRAP: begin
                    pc    <= TRAP_VECTOR;
                    i_req <= 1'b1;
                    state <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mc.sv
// Directed vector bench for core_mc: one table entry per instruction plus
// hand sequences for reset behaviour.
module tb_core_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_ready;
    logic [31:0] i_addr, i_rdata, instr, pc;
    logic [31:0] ex_pc_next, ex_addr, ex_wdata;
    logic        ex_rd_wen, ex_is_load, ex_is_store;
    logic [1:0]  ex_size;
    logic        d_req, d_we, d_ready;
    logic [31:0] d_addr, d_wdata, d_rdata, load_data;
    logic [1:0]  d_size;
    logic        rf_we, trap;
    logic [7:0]  irq, irq_mask;
    logic [4:0]  trap_cause;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_mc #(
        .XLEN(32), .RST_PC_ADDRESS(32'h0), .TRAP_VECTOR(32'h100),
        .NUM_IRQ(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .instr(instr), .pc(pc),
        .ex_pc_next(ex_pc_next), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_size(ex_size),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_ready(d_ready), .d_rdata(d_rdata), .load_data(load_data), .rf_we(rf_we),
        .irq(irq), .irq_mask(irq_mask),
        .trap(trap), .trap_cause(trap_cause), .epc(epc)
    );

    typedef struct {
        logic [31:0] pc, iword, pc_next;
        logic        rd_wen, ld, st;
        logic [31:0] addr, wdata;
        logic [1:0]  size;
        int          i_wait, d_wait;
        logic [31:0] rdata;
        logic [7:0]  irq, mask;
        int          lat, rf;
        logic        trap;
        logic [4:0]  cause;
        logic [31:0] epc, nxt, ld_data;
        int          dreq;
        logic        dwe;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_ir = 32'h0000_0013;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc_, iword, pc_next, input logic rd_wen, ld, st,
                       input logic [31:0] addr, wdata, input logic [1:0] size,
                       input int i_wait, d_wait, input logic [31:0] rdata,
                       input logic [7:0] irq_, mask, input int lat, rf,
                       input logic trap_, input logic [4:0] cause, input logic [31:0] epc_, nxt, ld_data,
                       input int dreq, input logic dwe);
        vec_t v;
        v = '{pc:pc_, iword:iword, pc_next:pc_next, rd_wen:rd_wen, ld:ld, st:st, addr:addr,
              wdata:wdata, size:size, i_wait:i_wait, d_wait:d_wait, rdata:rdata, irq:irq_,
              mask:mask, lat:lat, rf:rf, trap:trap_, cause:cause, epc:epc_, nxt:nxt,
              ld_data:ld_data, dreq:dreq, dwe:dwe};
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int n, cyc, wi, wd, rf_cnt, rf_cyc, dq_cnt, tr_cnt;
        logic dwe_seen, hold_ok, saw_drop, done, fetch_tmo;
        logic [4:0]  g_cause;
        logic [31:0] g_epc, g_daddr, g_dwdata;
        n = 0;
        while (!i_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", k, {31'b0, i_req}, 32'd1);
        chk("fetch_addr", k, i_addr, v.pc);
        ex_pc_next = v.pc_next; ex_rd_wen = v.rd_wen; ex_is_load = v.ld; ex_is_store = v.st;
        ex_addr = v.addr; ex_wdata = v.wdata; ex_size = v.size;
        irq = v.irq; irq_mask = v.mask; i_rdata = v.iword; d_rdata = v.rdata;
        cyc = 1; wi = v.i_wait; wd = v.d_wait; rf_cnt = 0; rf_cyc = 0; dq_cnt = 0; tr_cnt = 0;
        dwe_seen = 0; hold_ok = 1; saw_drop = 0; done = 0;
        g_cause = '0; g_epc = '0; g_daddr = '0; g_dwdata = '0;
        for (int it = 0; it < 60 && !done; it++) begin
            i_ready = 1'b0;
            d_ready = 1'b0;
            if (i_req) begin
                if (wi == 0) i_ready = 1'b1;
                else begin
                    wi--;
                    if (i_addr !== v.pc || instr !== exp_ir) hold_ok = 0;
                end
            end
            if (d_req) begin
                if (dq_cnt == 0) begin g_daddr = d_addr; g_dwdata = d_wdata; end
                dq_cnt++;
                if (d_we) dwe_seen = 1;
                if (wd == 0) d_ready = 1'b1; else wd--;
            end
            if (rf_we) begin rf_cnt++; rf_cyc = cyc; end
            if (trap) begin tr_cnt++; g_cause = trap_cause; g_epc = epc; end
            @(negedge clk);
            if (!i_req) saw_drop = 1;
            else if (saw_drop) done = 1;
            if (!done) cyc++;
        end
        i_ready = 1'b0;
        d_ready = 1'b0;
        fetch_tmo = v.trap && v.cause == 5'd1;
        if (!fetch_tmo) exp_ir = v.iword;
        chk("complete", k, {31'b0, done}, 32'd1);
        chk("latency", k, cyc, v.lat);
        chk("fetch_hold", k, {31'b0, hold_ok}, 32'd1);
        chk("instr", k, instr, exp_ir);
        chk("rf_we_count", k, rf_cnt, v.rf);
        if (v.rf > 0) chk("rf_we_cycle", k, rf_cyc, v.trap ? v.lat - 1 : v.lat);
        chk("trap_count", k, tr_cnt, {31'b0, v.trap});
        if (v.trap) begin
            chk("trap_cause", k, {27'b0, g_cause}, {27'b0, v.cause});
            chk("epc", k, g_epc, v.epc);
        end
        chk("next_pc", k, i_addr, v.nxt);
        chk("load_data", k, load_data, v.ld_data);
        chk("d_req_cycles", k, dq_cnt, v.dreq);
        chk("d_we", k, {31'b0, dwe_seen}, {31'b0, v.dwe});
        if (v.dreq > 0) chk("d_addr", k, g_daddr, v.addr);
        if (v.dreq > 0 && v.st) chk("d_wdata", k, g_dwdata, v.wdata);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; i_ready = 0; d_ready = 0; i_rdata = 0; d_rdata = 0;
        ex_pc_next = 0; ex_rd_wen = 0; ex_is_load = 0; ex_is_store = 0;
        ex_addr = 0; ex_wdata = 0; ex_size = 0; irq = 0; irq_mask = 0;

        //   pc       iword        next     wen ld st addr      wdata        sz iw  dw  rdata        irq    mask   lat rf tr cause   epc      nxt      ld_data      dq dwe
        add(32'h000, 32'h00500093, 32'h004, 1, 0, 0, 32'h0,    32'h0,       2, 0,  0, 32'h0,       8'h00, 8'h00, 3, 1, 0, 5'h00, 32'h0,   32'h004, 32'h0,        0, 0);
        add(32'h004, 32'h00108113, 32'h008, 1, 0, 0, 32'h0,    32'h0,       2, 5,  0, 32'h0,       8'h00, 8'h00, 8, 1, 0, 5'h00, 32'h0,   32'h008, 32'h0,        0, 0);
        add(32'h008, 32'h00002183, 32'h00C, 1, 1, 0, 32'h2000, 32'h0,       2, 0,  2, 32'hDEADBEEF,8'h00, 8'h00, 6, 1, 0, 5'h00, 32'h0,   32'h00C, 32'hDEADBEEF, 3, 0);
        add(32'h00C, 32'h001010A3, 32'h010, 0, 0, 1, 32'h2001, 32'hBEEF,    1, 0,  0, 32'h0,       8'h00, 8'h00, 3, 0, 1, 5'h06, 32'h00C, 32'h100, 32'hDEADBEEF, 0, 0);
        add(32'h100, 32'h04000063, 32'h040, 0, 0, 0, 32'h0,    32'h0,       2, 0,  0, 32'h0,       8'h00, 8'h00, 3, 0, 0, 5'h00, 32'h0,   32'h040, 32'hDEADBEEF, 0, 0);
        add(32'h040, 32'h00100093, 32'h044, 1, 0, 0, 32'h0,    32'h0,       2, 0,  0, 32'h0,       8'h24, 8'hFF, 4, 1, 1, 5'h12, 32'h044, 32'h100, 32'hDEADBEEF, 0, 0);
        add(32'h100, 32'h00612023, 32'h104, 1, 0, 1, 32'h3000, 32'h12345678,2, 0,  0, 32'h0,       8'h00, 8'h00, 4, 0, 0, 5'h00, 32'h0,   32'h104, 32'hDEADBEEF, 1, 1);
        add(32'h104, 32'h00100093, 32'h108, 1, 0, 0, 32'h0,    32'h0,       2, 0,  0, 32'h0,       8'h80, 8'h7F, 3, 1, 0, 5'h00, 32'h0,   32'h108, 32'hDEADBEEF, 0, 0);
        add(32'h108, 32'h00301083, 32'h10C, 1, 1, 0, 32'h2003, 32'h0,       1, 0,  0, 32'h0,       8'h00, 8'h00, 3, 0, 1, 5'h04, 32'h108, 32'h100, 32'hDEADBEEF, 0, 0);
        add(32'h100, 32'h00300083, 32'h104, 1, 1, 0, 32'h2003, 32'h0,       0, 0,  0, 32'hA5,      8'hC1, 8'hF0, 5, 1, 1, 5'h16, 32'h104, 32'h100, 32'hA5,        1, 0);
        add(32'h100, 32'h00000013, 32'h104, 1, 0, 0, 32'h0,    32'h0,       2, 0,  0, 32'h0,       8'h00, 8'h00, 3, 1, 0, 5'h00, 32'h0,   32'h104, 32'hA5,        0, 0);
`ifdef CORE_MC_BUS_TIMEOUT_EN
        add(32'h104, 32'h00002183, 32'h108, 1, 1, 0, 32'h2000, 32'h0,       2, 0,100, 32'h55555555,8'h00, 8'h00, 7, 0, 1, 5'h05, 32'h104, 32'h100, 32'hA5,        4, 0);
        add(32'h100, 32'h00612223, 32'h104, 0, 0, 1, 32'h3004, 32'hCAFEF00D,2, 0,  3, 32'h0,       8'h00, 8'h00, 7, 0, 0, 5'h00, 32'h0,   32'h104, 32'hA5,        4, 1);
        add(32'h104, 32'h11111111, 32'h108, 1, 0, 0, 32'h0,    32'h0,       2,100, 0, 32'h0,       8'h00, 8'h00, 5, 0, 1, 5'h01, 32'h104, 32'h100, 32'hA5,        0, 0);
`endif

        repeat (3) @(negedge clk);
        chk("rst_i_req", -1, {31'b0, i_req}, 32'd0);
        chk("rst_d_req", -1, {31'b0, d_req}, 32'd0);
        chk("rst_d_we", -1, {31'b0, d_we}, 32'd0);
        chk("rst_rf_we", -1, {31'b0, rf_we}, 32'd0);
        chk("rst_trap", -1, {31'b0, trap}, 32'd0);
        chk("rst_pc", -1, pc, 32'h0);
        chk("rst_instr", -1, instr, 32'h0000_0013);
        chk("rst_epc", -1, epc, 32'h0);
        chk("rst_cause", -1, {27'b0, trap_cause}, 32'h0);
        chk("rst_load_data", -1, load_data, 32'h0);
        chk("rst_d_addr", -1, d_addr, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Reset while a load waits in MEM: the pending ready must be ignored.
        ex_is_load = 1; ex_is_store = 0; ex_rd_wen = 1; ex_addr = 32'h2000; ex_size = 2;
        irq = 0; irq_mask = 0;
        n = 0;
        while (!i_req && n < 20) begin @(negedge clk); n++; end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        n = 0;
        while (!d_req && n < 5) begin @(negedge clk); n++; end
        chk("mid_mem_d_req", 99, {31'b0, d_req}, 32'd1);
        rst_n = 1'b0; d_ready = 1'b1; d_rdata = 32'h77777777;
        @(negedge clk);
        d_ready = 1'b0;
        chk("mid_rst_d_req", 99, {31'b0, d_req}, 32'd0);
        chk("mid_rst_pc", 99, pc, 32'h0);
        chk("mid_rst_rf_we", 99, {31'b0, rf_we}, 32'd0);
        chk("mid_rst_load_data", 99, load_data, 32'h0);
        chk("mid_rst_instr", 99, instr, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!i_req && n < 5) begin
            chk("post_rst_rf_we", 99, {31'b0, rf_we}, 32'd0);
            @(negedge clk);
            n++;
        end
        chk("post_rst_fetch", 99, {31'b0, i_req}, 32'd1);
        chk("post_rst_addr", 99, i_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
